// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver and its consumers.
// Holds prefix bytes, game keycodes and the frame FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Odd parity over data plus parity bit, and a high stop bit.
    function automatic logic frame_ok(input logic [7:0] data_byte,
                                      input logic       parity_bit,
                                      input logic       stop_bit);
        return (^{parity_bit, data_byte}) & stop_bit;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded key stream from the PS/2 receiver to the game state machine.
interface ps2_keyboard_rx_if;
    logic [7:0] keycode;
    logic       key_extended;
    logic       new_key_strobe;
    logic       frame_error;

    modport master (output keycode, key_extended, new_key_strobe, frame_error);
    modport slave  (input  keycode, key_extended, new_key_strobe, frame_error);
endinterface

// File: rtl/ps2_keyboard_rx_filter.sv
// Synchronizes the raw PS/2 pins, glitch-filters ps2_clk and emits a
// one-cycle pulse on each falling edge of the filtered clock.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          clk_meta, clk_sync;
    logic          data_meta, data_sync_q;
    logic          clk_filt;
    logic [CW-1:0] cnt;
    logic          fall_q;

    // Idle PS/2 lines are high, so the flops reset high to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta    <= 1'b1;
            clk_sync    <= 1'b1;
            data_meta   <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop take the pre-edge value of the previous one.
            clk_meta    <= ps2_clk;
            clk_sync    <= clk_meta;
            data_meta   <= ps2_data;
            data_sync_q <= data_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            cnt      <= '0;
            fall_q   <= 1'b0;
        end else if (clk_sync != clk_filt) begin
            if (cnt == CNT_LAST) begin
                clk_filt <= clk_sync;
                cnt      <= '0;
                fall_q   <= ~clk_sync;
            end else begin
                cnt    <= cnt + 1'b1;
                fall_q <= 1'b0;
            end
        end else begin
            cnt    <= '0;
            fall_q <= 1'b0;
        end
    end

    assign clk_fall  = fall_q;
    assign data_sync = data_sync_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame FSM, scan-code decoder (F0 break, E0 extended)
// and a stretched new-key strobe slow enough for the 5 Hz game clock.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STROBE_CYCLES  = 5000000
) (
    input  logic               clk_25MHz,
    input  logic               rst_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_keyboard_rx_if.master  key
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STROBE_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STROBE_LOAD  = SW'(STROBE_CYCLES);

    logic fall, data_s;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk_25MHz),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (fall),
        .data_sync (data_s)
    );

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_q;
    logic [TW-1:0] timeout_cnt;
    logic          break_flag, ext_flag;
    logic [7:0]    keycode_q;
    logic          key_ext_q;
    logic          frame_error_q;
    logic [SW-1:0] strobe_cnt;

    logic shift_en, parity_en, frame_done, byte_ok, timeout_hit, err, make_en;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE:    if (!data_s) state_d = DATA;
                DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en    = fall && (state_q == DATA);
        parity_en   = fall && (state_q == PARITY);
        frame_done  = fall && (state_q == STOP);
        byte_ok     = frame_done && frame_ok(shift_reg, parity_q, data_s);
        timeout_hit = (state_q != IDLE) && !fall && (timeout_cnt == TIMEOUT_LAST);
        err         = (frame_done && !byte_ok) || timeout_hit;
        make_en     = byte_ok && !break_flag &&
                      (shift_reg != BREAK_CODE) && (shift_reg != EXT_CODE);
    end

    // NOTE: the shift register is reset with the rest of the datapath so a frame cut short by reset leaves nothing behind.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_q      <= 1'b0;
            timeout_cnt   <= '0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= err;
            if (state_q == IDLE || fall) timeout_cnt <= '0;
            else                         timeout_cnt <= timeout_cnt + 1'b1;
            if (state_q == IDLE)   bit_cnt <= '0;
            else if (shift_en)     bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)  shift_reg <= {data_s, shift_reg[7:1]};
            if (parity_en) parity_q  <= data_s;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
            keycode_q  <= 8'h00;
            key_ext_q  <= 1'b0;
        end else if (err) begin
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
        end else if (byte_ok) begin
            if (shift_reg == BREAK_CODE) begin
                break_flag <= 1'b1;
            end else if (shift_reg == EXT_CODE) begin
                ext_flag <= 1'b1;
            end else if (break_flag) begin
                break_flag <= 1'b0;
                ext_flag   <= 1'b0;
            end else begin
                keycode_q <= shift_reg;
                key_ext_q <= ext_flag;
                ext_flag  <= 1'b0;
            end
        end
    end

    // A make during an active window reloads the counter, so the strobe never gaps.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n)               strobe_cnt <= '0;
        else if (make_en)         strobe_cnt <= STROBE_LOAD;
        else if (strobe_cnt != 0) strobe_cnt <= strobe_cnt - 1'b1;
    end

    assign key.keycode        = keycode_q;
    assign key.key_extended   = key_ext_q;
    assign key.new_key_strobe = (strobe_cnt != '0);
    assign key.frame_error    = frame_error_q;

endmodule
